// File: rtl/knights_pkg.sv
// Shared types and constants for the UART command wrapper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package knights_pkg;

  // Command assembler: waiting for the high byte, then the low byte
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

  // 19200 baud from a 50 MHz clock
  localparam int BAUD_DIV_DEF     = 2604;
  // Clocks allowed between the high and low command bytes (20 ms at 50 MHz)
  localparam int TIMEOUT_CLKS_DEF = 1000000;
  // Positive acknowledge byte returned to the host
  localparam logic [7:0] POS_ACK  = 8'hA5;

endpackage

// File: rtl/uart_byte_xcvr.sv
// 8N1 UART bit engines: receiver and transmitter, independent and concurrent.
// Latency: rx_vld pulses in the stop-bit sample cycle; tx_done rises 1 clk after the stop bit ends.
// Backpressure: none on RX (bytes are pulses); trmt is ignored while a TX frame is in progress.
module uart_byte_xcvr
  import knights_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       rx_start,
  output logic       rx_busy,
  input  logic [7:0] tx_dat,
  input  logic       trmt,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  logic          rx_ff1, rx_ff2, rx_prev;
  logic          rx_fall, rx_smp;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_shift;

  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;
  logic          tx_busy, tx_fin;

  // Synchronize RX; preset high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  assign rx_fall  = rx_prev & ~rx_ff2;
  assign rx_start = rx_fall & ~rx_busy;
  assign rx_smp   = rx_busy && (rx_cnt == '0);
  assign rx_vld   = rx_smp && (rx_idx == 4'd9) && rx_ff2;
  assign rx_dat   = rx_shift;

  // Receive: sample start at mid-bit, then every bit period; a high start sample is a glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else if (rx_start) begin
      rx_busy <= 1'b1;
      rx_cnt  <= HALF;
      rx_idx  <= '0;
    end else if (rx_busy) begin
      if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CW'(1);
      end else begin
        rx_cnt <= FULL;
        rx_idx <= rx_idx + 4'd1;
        if (rx_idx == 4'd0) begin
          if (rx_ff2) rx_busy <= 1'b0;
        end else if (rx_idx == 4'd9) begin
          rx_busy <= 1'b0;
        end else begin
          rx_shift <= {rx_ff2, rx_shift[7:1]};
        end
      end
    end
  end

  assign TX = tx_shift[0];

  // Transmit: shift out {stop, data, start} LSB first, one bit per BAUD_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_busy  <= 1'b0;
      tx_fin   <= 1'b0;
      tx_done  <= 1'b0;
    end else if (trmt && !tx_busy) begin
      tx_shift <= {1'b1, tx_dat, 1'b0};
      tx_cnt   <= FULL;
      tx_idx   <= '0;
      tx_busy  <= 1'b1;
      tx_fin   <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_fin <= 1'b0;
      if (tx_fin) tx_done <= 1'b1;
      if (tx_busy) begin
        if (tx_cnt != '0) begin
          tx_cnt <= tx_cnt - CW'(1);
        end else begin
          tx_cnt   <= FULL;
          tx_shift <= {1'b1, tx_shift[9:1]};
          if (tx_idx == 4'd9) begin
            tx_busy <= 1'b0;
            tx_fin  <= 1'b1;
          end else begin
            tx_idx <= tx_idx + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two received UART bytes into a 16-bit command and transmits response bytes.
// Latency: cmd_rdy rises 1 clk after the low byte's stop-bit sample; tx_done 10*BAUD_DIV+1 clks after trmt.
// Backpressure: none; a new command overwrites an unconsumed one. Optional define CMD_TIMEOUT_EN adds an inter-byte timeout.
module uart_cmd_wrapper
  import knights_pkg::*;
#(
  parameter int BAUD_DIV     = BAUD_DIV_DEF,
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  asm_state_t state, state_nxt;
  logic [7:0] rx_dat, hi_byte;
  logic       rx_vld, rx_start, rx_busy;
  logic       ld_hi, ld_cmd, timeout;

  uart_byte_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .TX       (TX),
    .rx_dat   (rx_dat),
    .rx_vld   (rx_vld),
    .rx_start (rx_start),
    .rx_busy  (rx_busy),
    .tx_dat   (resp),
    .trmt     (trmt),
    .tx_done  (tx_done)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmr;

  // Count idle clocks while a low byte is awaited; any receive activity restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (state != WAIT_LO || rx_busy || rx_start) begin
      tmr <= '0;
    end else if (!timeout) begin
      tmr <= tmr + TW'(1);
    end
  end

  assign timeout = (state == WAIT_LO) && !rx_busy && !rx_start && (tmr == TW'(TIMEOUT_CLKS - 1));
`else
  logic timeout_unused;
  assign timeout        = 1'b0;
  assign timeout_unused = (TIMEOUT_CLKS == 0);
`endif

  // Assembler state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_HI;
    else     state <= state_nxt;
  end

  // Assembler next state: accepted bytes alternate high/low; timeout drops a stale high byte
  always_comb begin
    state_nxt = state;
    ld_hi     = 1'b0;
    ld_cmd    = 1'b0;
    case (state)
      WAIT_HI: begin
        if (rx_vld) begin
          ld_hi     = 1'b1;
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_vld) begin
          ld_cmd    = 1'b1;
          state_nxt = WAIT_HI;
        end else if (timeout) begin
          state_nxt = WAIT_HI;
        end
      end
      default: state_nxt = WAIT_HI;
    endcase
  end

  // Command and ready flag; setting takes priority over any clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_byte <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (ld_hi) hi_byte <= rx_dat;
      if (ld_cmd) begin
        cmd     <= {hi_byte, rx_dat};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || (rx_start && state == WAIT_HI)) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
module tb_uart_cmd_wrapper;
  import knights_pkg::*;

  localparam int B  = 16;
  localparam int TO = 200;
  localparam int RDY_EDGE = 3 + B / 2 + 9 * B;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0]  resp;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT_CLKS(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  // Drive one 8N1 frame from a negedge; rise = posedge index (1-based) where cmd_rdy went high, 0 if none
  task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_edge, output int rise);
    logic [9:0] f;
    logic       prev;
    f    = {stop, d, 1'b0};
    rise = 0;
    prev = cmd_rdy;
    for (int n = 1; n <= 10 * B; n++) begin
      RX          = f[(n - 1) / B];
      clr_cmd_rdy = (n == clr_edge);
      @(negedge clk);
      if (cmd_rdy && !prev && rise == 0) rise = n;
      prev = cmd_rdy;
    end
    clr_cmd_rdy = 1'b0;
    RX          = 1'b1;
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++; if (TX !== 1'b1)     begin n_miss++; $display("FAIL reset_tx: got %b want 1", TX); end
    n_vec++; if (cmd !== 16'h0)   begin n_miss++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    n_vec++; if (tx_done !== 1'b0) begin n_miss++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd_basic();
    int r;
    send_frame(8'h4B, 1'b1, 0, r);
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL basic_hi_only: cmd_rdy got %b want 0", cmd_rdy); end
    send_frame(8'hF1, 1'b1, 0, r);
    n_vec++; if (r != RDY_EDGE) begin n_miss++; $display("FAIL basic_latency: rdy edge got %0d want %0d", r, RDY_EDGE); end
    n_vec++; if (cmd !== 16'h4BF1) begin n_miss++; $display("FAIL basic_cmd: got %h want 4bf1", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_miss++; $display("FAIL basic_rdy_hold: got %b want 1", cmd_rdy); end
    pulse_clr();
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL basic_clr: got %b want 0", cmd_rdy); end
  endtask

  task automatic test_set_clr_collision();
    int r;
    send_frame(8'h20, 1'b1, 0, r);
    send_frame(8'h00, 1'b1, RDY_EDGE, r);
    n_vec++; if (r != RDY_EDGE) begin n_miss++; $display("FAIL coll_set_wins: rdy edge got %0d want %0d", r, RDY_EDGE); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_miss++; $display("FAIL coll_rdy: got %b want 1", cmd_rdy); end
    n_vec++; if (cmd !== 16'h2000) begin n_miss++; $display("FAIL coll_cmd: got %h want 2000", cmd); end
    pulse_clr();
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL coll_next_clr: got %b want 0", cmd_rdy); end
    n_vec++; if (cmd !== 16'h2000) begin n_miss++; $display("FAIL coll_cmd_kept: got %h want 2000", cmd); end
  endtask

  task automatic test_tx();
    logic [9:0] fr;
    int         done_at;
    fr      = {1'b1, POS_ACK, 1'b0};
    done_at = 0;
    resp = POS_ACK; trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    n_vec++; if (tx_done !== 1'b0) begin n_miss++; $display("FAIL tx_done_early: got %b want 0", tx_done); end
    for (int n = 0; n <= 10 * B + 4; n++) begin
      if (n < 10 * B && (n % B) == B / 2) begin
        n_vec++;
        if (TX !== fr[n / B]) begin n_miss++; $display("FAIL tx_bit%0d: got %b want %b", n / B, TX, fr[n / B]); end
      end
      if (n == 3 * B + 2) begin resp = 8'h00; trmt = 1'b1; end
      else trmt = 1'b0;
      if (tx_done === 1'b1 && done_at == 0) done_at = n;
      @(negedge clk);
    end
    n_vec++; if (done_at != 10 * B + 1) begin n_miss++; $display("FAIL tx_done_latency: got %0d want %0d", done_at, 10 * B + 1); end
    n_vec++; if (TX !== 1'b1) begin n_miss++; $display("FAIL tx_idle: got %b want 1", TX); end
    resp = 8'h3C; trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    n_vec++; if (tx_done !== 1'b0) begin n_miss++; $display("FAIL tx_done_clear: got %b want 0", tx_done); end
    n_vec++; if (TX !== 1'b0) begin n_miss++; $display("FAIL tx_second_start: got %b want 0", TX); end
    repeat (10 * B + 4) @(negedge clk);
    n_vec++; if (tx_done !== 1'b1) begin n_miss++; $display("FAIL tx_second_done: got %b want 1", tx_done); end
  endtask

  task automatic test_bad_stop();
    int r;
    send_frame(8'h40, 1'b0, 0, r);
    send_frame(8'h40, 1'b1, 0, r);
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL bad_no_cmd: cmd_rdy got %b want 0", cmd_rdy); end
    send_frame(8'h02, 1'b1, 0, r);
    n_vec++; if (cmd !== 16'h4002) begin n_miss++; $display("FAIL bad_cmd: got %h want 4002", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_miss++; $display("FAIL bad_rdy: got %b want 1", cmd_rdy); end
  endtask

  task automatic test_reset_mid();
    int         r;
    logic [9:0] f;
    send_frame(8'h4B, 1'b1, 0, r);
    f = {1'b1, 8'hF1, 1'b0};
    for (int n = 1; n <= 5 * B; n++) begin
      RX = f[(n - 1) / B];
      @(negedge clk);
    end
    rst = 1'b1; RX = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (TX !== 1'b1)      begin n_miss++; $display("FAIL rmid_tx: got %b want 1", TX); end
    n_vec++; if (cmd !== 16'h0)    begin n_miss++; $display("FAIL rmid_cmd: got %h want 0000", cmd); end
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL rmid_rdy: got %b want 0", cmd_rdy); end
    n_vec++; if (tx_done !== 1'b0) begin n_miss++; $display("FAIL rmid_tx_done: got %b want 0", tx_done); end
    rst = 1'b0;
    repeat (2 * B) @(negedge clk);
    send_frame(8'h43, 1'b1, 0, r);
    send_frame(8'hF2, 1'b1, 0, r);
    n_vec++; if (cmd !== 16'h43F2) begin n_miss++; $display("FAIL rmid_after_cmd: got %h want 43f2", cmd); end
    n_vec++; if (r != RDY_EDGE) begin n_miss++; $display("FAIL rmid_after_latency: got %0d want %0d", r, RDY_EDGE); end
  endtask

  task automatic test_timeout();
    int r;
    pulse_clr();
    send_frame(8'h43, 1'b1, 0, r);
    repeat (TO + 10) @(negedge clk);
    send_frame(8'h47, 1'b1, 0, r);
`ifdef CMD_TIMEOUT_EN
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL to_stale_hi: cmd_rdy got %b want 0", cmd_rdy); end
    send_frame(8'hF2, 1'b1, 0, r);
    n_vec++; if (cmd !== 16'h47F2) begin n_miss++; $display("FAIL to_cmd: got %h want 47f2", cmd); end
`else
    n_vec++; if (cmd !== 16'h4347) begin n_miss++; $display("FAIL no_to_cmd: got %h want 4347", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_miss++; $display("FAIL no_to_rdy: got %b want 1", cmd_rdy); end
`endif
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_set_clr_collision();
    test_tx();
    test_bad_stop();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
